tabuleiro_pecas: RTL and testbench
==================================

# tabuleiro_pecas

Board store and conflict checker for the piece-placement stage. It accepts one placement request per handshake: player, piece type, anchor X/Y, direction and orientation. It expands the request into board cells, checks every cell for out-of-bounds or overlap, writes the piece into that player's 8x8 grid when clean, and returns `conflito` to the placement FSM. It also exposes a registered read port for the display and attack stages.

## Interface
- `N_CEL`, 8: grid side; coordinates are 3-bit.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `valida` input 1: request strobe from the placement stage.
- `jogador` input 1: player index (0/1).
- `tipo` input 3: piece type.
- `X1`, `Y1` input 3 each: anchor cell.
- `direcao` input 1: 0 = horizontal (X steps), 1 = vertical (Y steps).
- `orientacao` input 1: 0 = positive growth, 1 = negative growth.
- `limpa` input 1: synchronous clear of both grids.
- `conflito` output 1: result of the last request; held until the next request.
- `resposta` output 1: one-cycle pulse; `conflito` is valid in that cycle.
- `ocupado` output 1: high while a request is in progress.
- `rd_jogador` input 1, `rd_x` input 3, `rd_y` input 3: read address.
- `rd_ocupado` output 1: registered occupancy of the addressed cell.
- `rd_tipo` output 3: registered type of the addressed cell.
- `celulas_j0`, `celulas_j1` output 5 each: occupied-cell counts per player.

## Operation
- Piece shapes (offsets along the step axis a and the cross axis b), where k is the cell index:
  - tipo 0 porta-aviões: 5 cells, a = 0..4.
  - tipo 1 encouraçado: 4 cells, a = 0..3.
  - tipo 2 hidroavião: 3 cells, (a,b) = (0,0), (1,1), (2,0).
  - tipo 3 cruzador: 2 cells, a = 0..1.
  - tipo 4 submarino: 1 cell.
  - tipo 5..7: treated as conflict immediately.
- `orientacao` = 1 negates both a and b.
- Cell coordinates are computed in 4-bit signed arithmetic. Any coordinate outside 0..7 is a conflict.
- FSM states and transitions:
  - IDLE: `valida` = 1 latches all request fields and moves to CHECK, k = 0. `conflito` clears at the same edge.
  - CHECK: tests cell k, one per cycle.
    - Conflict: set `conflito` and go to DONE.
    - Last cell clean: go to WRITE with k = 0.
    - Otherwise k increments.
  - WRITE: sets cell k (occupancy and type), one per cycle, and increments that player's count. After the last cell, go to DONE.
  - DONE: `resposta` = 1 for one cycle, then return to IDLE.
- `valida` outside IDLE is ignored. Grids are never partially written.
- `limpa` in any state clears the grids and counters, clears `conflito`, and forces IDLE with no `resposta`.
- `limpa` and `valida` in the same IDLE cycle: `limpa` wins and the request is dropped.

## Timing
- Reset values: all grids 0, counts 0, `conflito` 0, `resposta` 0, `ocupado` 0, `rd_ocupado` 0, `rd_tipo` 0, FSM in IDLE.
- Let L be the piece length and t0 the edge that samples `valida`.
- Clean request: CHECK occupies cycles 1..L, WRITE occupies L+1..2L, and `resposta` is high in cycle 2L+1.
- Conflict at cell k: `resposta` is high in cycle k+2.
- Invalid tipo: `resposta` is high in cycle 2.
- `ocupado` is high from cycle 1 through the DONE cycle inclusive.
- Read port: one-cycle latency. A read of a cell written at edge t returns the new value when the address is sampled at edge t+1 or later.

## Configuration
- `TABULEIRO_TIPO_EN`:
  - Defined: a 3-bit type is stored per cell and `rd_tipo` returns it.
  - Undefined: only the occupancy bit is stored and `rd_tipo` is constant 0.
  - Occupancy, conflict behaviour and timing are identical in both builds.

## Structure
- Shared package (`batalha_pkg`) holds:
  - Type encodings TIPO_PORTA_AVIOES..TIPO_SUBMARINO.
  - The length table.
  - The hidroavião offset table.
  - Direction/orientation constants.
  - FSM state encoding.
- One sub-module is natural: `gera_celula`, a combinational block taking (tipo, k, X1, Y1, direcao, orientacao) and producing cell x, y, out-of-bounds flag and last-cell flag.

## Test plan
- Empty board, j0, tipo 0 at (2,2), direcao 0, orientacao 0 -> `conflito` = 0, `resposta` in cycle 11, cells (2..6,2) read occupied, `celulas_j0` = 5.
- Then j0, tipo 1 at (4,0), direcao 1, orientacao 0 -> overlap at k = 2, `conflito` = 1, `resposta` in cycle 4, board unchanged, count stays 5.
- j1, tipo 0 at (5,0), direcao 0, orientacao 0 -> out-of-bounds at k = 3, `conflito` = 1; same request for j1 at (4,4) with orientacao 1 -> clean, cells (0..4,4).
- j0, tipo 2 at (0,5), direcao 1, orientacao 0 -> cells (0,5), (1,6), (0,7) occupied; `rd_tipo` = 2 with `TABULEIRO_TIPO_EN` defined, 0 without.
- Player isolation: same placement for j1 as an existing j0 piece -> `conflito` = 0.
- Abort cases:
  - `valida` during WRITE -> ignored.
  - `limpa` in WRITE cycle 2 -> grids and counts 0, no `resposta`.
  - `reset` low mid-CHECK -> all outputs at reset values immediately.

Source files
------------

// File: rtl/batalha_pkg.sv
// Shared definitions for the board stage: piece encodings, shape tables,
// axis constants and the placement FSM state encoding.
package batalha_pkg;

  localparam int N_CEL = 8;

  localparam logic [2:0] TIPO_PORTA_AVIOES = 3'd0;
  localparam logic [2:0] TIPO_ENCOURACADO  = 3'd1;
  localparam logic [2:0] TIPO_HIDROAVIAO   = 3'd2;
  localparam logic [2:0] TIPO_CRUZADOR     = 3'd3;
  localparam logic [2:0] TIPO_SUBMARINO    = 3'd4;

  localparam logic DIR_HORIZONTAL = 1'b0;
  localparam logic DIR_VERTICAL   = 1'b1;
  localparam logic ORI_POSITIVA   = 1'b0;
  localparam logic ORI_NEGATIVA   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } estado_t;

  // Piece length in cells; 0 marks an invalid type.
  function automatic logic [2:0] comprimento(input logic [2:0] tipo);
    case (tipo)
      TIPO_PORTA_AVIOES: comprimento = 3'd5;
      TIPO_ENCOURACADO:  comprimento = 3'd4;
      TIPO_HIDROAVIAO:   comprimento = 3'd3;
      TIPO_CRUZADOR:     comprimento = 3'd2;
      TIPO_SUBMARINO:    comprimento = 3'd1;
      default:           comprimento = 3'd0;
    endcase
  endfunction

  // Seaplane step-axis offset for cell k: (0,0), (1,1), (2,0).
  function automatic logic [3:0] hidro_a(input logic [2:0] k);
    case (k)
      3'd0:    hidro_a = 4'd0;
      3'd1:    hidro_a = 4'd1;
      3'd2:    hidro_a = 4'd2;
      default: hidro_a = 4'd0;
    endcase
  endfunction

  // Seaplane cross-axis offset for cell k.
  function automatic logic [3:0] hidro_b(input logic [2:0] k);
    hidro_b = (k == 3'd1) ? 4'd1 : 4'd0;
  endfunction

endpackage

// File: rtl/tabuleiro_pecas_gera_celula.sv
// gera_celula: maps (tipo, k, anchor, direcao, orientacao) to one board cell.
// Arithmetic is 4-bit signed, so bit 3 set means the coordinate left 0..7.
module gera_celula
  import batalha_pkg::*;
(
  input  logic [2:0] tipo,
  input  logic [2:0] k,
  input  logic [2:0] x1,
  input  logic [2:0] y1,
  input  logic       direcao,
  input  logic       orientacao,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic       fora,
  output logic       ultima
);

  logic [3:0] a, b, dx, dy, sx, sy;
  logic [2:0] len;

  // Shape offset, optional negation, axis mapping and bounds test.
  always_comb begin
    len = comprimento(tipo);
    a   = {1'b0, k};
    b   = 4'd0;
    if (tipo == TIPO_HIDROAVIAO) begin
      a = hidro_a(k);
      b = hidro_b(k);
    end
    if (orientacao == ORI_NEGATIVA) begin
      a = 4'd0 - a;
      b = 4'd0 - b;
    end
    if (direcao == DIR_HORIZONTAL) begin
      dx = a;
      dy = b;
    end else begin
      dx = b;
      dy = a;
    end
    sx     = {1'b0, x1} + dx;
    sy     = {1'b0, y1} + dy;
    x      = sx[2:0];
    y      = sy[2:0];
    fora   = sx[3] | sy[3] | (len == 3'd0);
    ultima = (k == (len - 3'd1));
  end

endmodule

// File: rtl/tabuleiro_pecas.sv
// tabuleiro_pecas: two 8x8 board grids with a placement conflict checker.
// Build option: define TABULEIRO_TIPO_EN to store a 3-bit type per cell and
// return it on rd_tipo; without it only occupancy is kept and rd_tipo is 0.
//
// state    | meaning
// ST_IDLE  | waiting for valida
// ST_CHECK | testing cell k for out-of-bounds or overlap
// ST_WRITE | writing cell k into the requesting player's grid
// ST_DONE  | resposta pulse, conflito valid
module tabuleiro_pecas
  import batalha_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       valida,
  input  logic       jogador,
  input  logic [2:0] tipo,
  input  logic [2:0] X1,
  input  logic [2:0] Y1,
  input  logic       direcao,
  input  logic       orientacao,
  input  logic       limpa,
  output logic       conflito,
  output logic       resposta,
  output logic       ocupado,
  input  logic       rd_jogador,
  input  logic [2:0] rd_x,
  input  logic [2:0] rd_y,
  output logic       rd_ocupado,
  output logic [2:0] rd_tipo,
  output logic [4:0] celulas_j0,
  output logic [4:0] celulas_j1
);

  estado_t    estado, prox;
  logic [2:0] k;
  logic       jog_r, dir_r, ori_r;
  logic [2:0] tipo_r, x1_r, y1_r;
  logic [2:0] cx, cy;
  logic       fora, ultima, colide;
  logic [5:0] idx;
  logic [63:0] occ [2];
  logic [4:0] celulas [2];

  gera_celula u_gera (
    .tipo       (tipo_r),
    .k          (k),
    .x1         (x1_r),
    .y1         (y1_r),
    .direcao    (dir_r),
    .orientacao (ori_r),
    .x          (cx),
    .y          (cy),
    .fora       (fora),
    .ultima     (ultima)
  );

  assign idx    = {cy, cx};
  assign colide = fora | occ[jog_r][idx];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= ST_IDLE;
    else        estado <= prox;
  end

  // Next-state logic; limpa overrides every state.
  always_comb begin
    prox = estado;
    case (estado)
      ST_IDLE:  if (valida) prox = ST_CHECK;
      ST_CHECK: if (colide) prox = ST_DONE;
                else if (ultima) prox = ST_WRITE;
      ST_WRITE: if (ultima) prox = ST_DONE;
      ST_DONE:  prox = ST_IDLE;
      default:  prox = ST_IDLE;
    endcase
    if (limpa) prox = ST_IDLE;
  end

  // Status outputs decoded from the state.
  always_comb begin
    ocupado  = (estado != ST_IDLE);
    resposta = (estado == ST_DONE) && !limpa;
  end

  // Request latch, cell index, conflict flag, occupancy grids and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k          <= 3'd0;
      jog_r      <= 1'b0;
      dir_r      <= 1'b0;
      ori_r      <= 1'b0;
      tipo_r     <= 3'd0;
      x1_r       <= 3'd0;
      y1_r       <= 3'd0;
      conflito   <= 1'b0;
      occ[0]     <= '0;
      occ[1]     <= '0;
      celulas[0] <= 5'd0;
      celulas[1] <= 5'd0;
    end else if (limpa) begin
      k          <= 3'd0;
      conflito   <= 1'b0;
      occ[0]     <= '0;
      occ[1]     <= '0;
      celulas[0] <= 5'd0;
      celulas[1] <= 5'd0;
    end else begin
      case (estado)
        ST_IDLE: if (valida) begin
          jog_r    <= jogador;
          tipo_r   <= tipo;
          x1_r     <= X1;
          y1_r     <= Y1;
          dir_r    <= direcao;
          ori_r    <= orientacao;
          k        <= 3'd0;
          conflito <= 1'b0;
        end
        ST_CHECK: begin
          if (colide)      conflito <= 1'b1;
          else if (ultima) k <= 3'd0;
          else             k <= k + 3'd1;
        end
        ST_WRITE: begin
          occ[jog_r][idx] <= 1'b1;
          celulas[jog_r]  <= celulas[jog_r] + 5'd1;
          k               <= k + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign celulas_j0 = celulas[0];
  assign celulas_j1 = celulas[1];

  // Registered occupancy read for the display and attack stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_ocupado <= 1'b0;
    else        rd_ocupado <= occ[rd_jogador][{rd_y, rd_x}];
  end

`ifdef TABULEIRO_TIPO_EN
  logic [2:0] tipo_mem [2][64];

  // Per-cell type store, written alongside the occupancy bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) begin
        tipo_mem[0][i] <= 3'd0;
        tipo_mem[1][i] <= 3'd0;
      end
    end else if (limpa) begin
      for (int i = 0; i < 64; i++) begin
        tipo_mem[0][i] <= 3'd0;
        tipo_mem[1][i] <= 3'd0;
      end
    end else if (estado == ST_WRITE) begin
      tipo_mem[jog_r][idx] <= tipo_r;
    end
  end

  // Registered type read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_tipo <= 3'd0;
    else        rd_tipo <= tipo_mem[rd_jogador][{rd_y, rd_x}];
  end
`else
  assign rd_tipo = 3'd0;
`endif

endmodule

// File: tb/tb_tabuleiro_pecas.sv
// Scoreboard bench for tabuleiro_pecas: each request pushes its expected
// conflito and resposta cycle; a monitor pops and compares on resposta.
module tb_tabuleiro_pecas;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valida = 1'b0, jogador = 1'b0, direcao = 1'b0, orientacao = 1'b0, limpa = 1'b0;
  logic [2:0] tipo = 3'd0, X1 = 3'd0, Y1 = 3'd0;
  logic       conflito, resposta, ocupado, rd_ocupado;
  logic       rd_jogador = 1'b0;
  logic [2:0] rd_x = 3'd0, rd_y = 3'd0, rd_tipo;
  logic [4:0] celulas_j0, celulas_j1;

  tabuleiro_pecas dut (
    .clk(clk), .reset(reset), .valida(valida), .jogador(jogador), .tipo(tipo),
    .X1(X1), .Y1(Y1), .direcao(direcao), .orientacao(orientacao), .limpa(limpa),
    .conflito(conflito), .resposta(resposta), .ocupado(ocupado),
    .rd_jogador(rd_jogador), .rd_x(rd_x), .rd_y(rd_y),
    .rd_ocupado(rd_ocupado), .rd_tipo(rd_tipo),
    .celulas_j0(celulas_j0), .celulas_j1(celulas_j1)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        conf;
    int unsigned ciclo;
  } esperado_t;

  esperado_t fila[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string nome, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", nome, got, exp);
    end
  endtask

  function automatic int tipo_esp(input int t);
`ifdef TABULEIRO_TIPO_EN
    return t;
`else
    return 0;
`endif
  endfunction

  // Monitor: every resposta pulse must match the oldest expectation.
  initial begin
    esperado_t e;
    forever begin
      @(negedge clk);
      if (resposta) begin
        if (fila.size() == 0) begin
          check("resposta_inesperada", 1, 0);
        end else begin
          e = fila.pop_front();
          check("conflito", int'(conflito), int'(e.conf));
          check("ciclo_resposta", int'(cyc), int'(e.ciclo));
        end
      end
    end
  end

  // Drives one request; leaves the bench at the negedge of cycle 1.
  task automatic inicia(input logic j, input logic [2:0] t, input logic [2:0] x,
                        input logic [2:0] y, input logic d, input logic o,
                        input bit empurra, input logic conf, input int lat);
    esperado_t e;
    @(negedge clk);
    jogador = j; tipo = t; X1 = x; Y1 = y; direcao = d; orientacao = o;
    valida = 1'b1;
    if (empurra) begin
      e.conf  = conf;
      e.ciclo = cyc + lat;
      fila.push_back(e);
    end
    @(negedge clk);
    valida = 1'b0;
  endtask

  task automatic espera_idle();
    int n = 0;
    while (ocupado && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (ocupado) check("timeout_ocupado", 1, 0);
  endtask

  task automatic req(input logic j, input logic [2:0] t, input logic [2:0] x,
                     input logic [2:0] y, input logic d, input logic o,
                     input logic conf, input int lat);
    inicia(j, t, x, y, d, o, 1'b1, conf, lat);
    espera_idle();
  endtask

  task automatic le(input string nome, input logic j, input logic [2:0] x,
                    input logic [2:0] y, input logic occ, input int t);
    @(negedge clk);
    rd_jogador = j; rd_x = x; rd_y = y;
    @(negedge clk);
    check({nome, "_ocupado"}, int'(rd_ocupado), int'(occ));
    check({nome, "_tipo"}, int'(rd_tipo), t);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_conflito", int'(conflito), 0);
    check("rst_resposta", int'(resposta), 0);
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_rd_ocupado", int'(rd_ocupado), 0);
    check("rst_rd_tipo", int'(rd_tipo), 0);
    check("rst_cel_j0", int'(celulas_j0), 0);
    check("rst_cel_j1", int'(celulas_j1), 0);

    // Aircraft carrier j0 at (2,2) horizontal: cells (2..6,2).
    req(1'b0, 3'd0, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0, 11);
    for (int i = 2; i <= 6; i++) le("pa_j0", 1'b0, 3'(i), 3'd2, 1'b1, tipo_esp(0));
    le("pa_j0_fora", 1'b0, 3'd7, 3'd2, 1'b0, 0);
    check("cel_j0_5", int'(celulas_j0), 5);

    // Battleship j0 at (4,0) vertical overlaps (4,2) at k=2.
    req(1'b0, 3'd1, 3'd4, 3'd0, 1'b1, 1'b0, 1'b1, 4);
    check("conflito_retido", int'(conflito), 1);
    le("enc_nao_escrito", 1'b0, 3'd4, 3'd0, 1'b0, 0);
    check("cel_j0_ainda_5", int'(celulas_j0), 5);

    // j1 carrier at (5,0): x reaches 8 at k=3.
    req(1'b1, 3'd0, 3'd5, 3'd0, 1'b0, 1'b0, 1'b1, 5);
    check("cel_j1_0", int'(celulas_j1), 0);
    // j1 carrier at (4,4) negative: cells (0..4,4).
    req(1'b1, 3'd0, 3'd4, 3'd4, 1'b0, 1'b1, 1'b0, 11);
    check("conflito_limpo", int'(conflito), 0);
    le("pa_j1_0", 1'b1, 3'd0, 3'd4, 1'b1, tipo_esp(0));
    le("pa_j1_4", 1'b1, 3'd4, 3'd4, 1'b1, tipo_esp(0));
    le("pa_j1_5", 1'b1, 3'd5, 3'd4, 1'b0, 0);
    check("cel_j1_5", int'(celulas_j1), 5);

    // Seaplane j0 at (0,5) vertical: (0,5), (1,6), (0,7).
    req(1'b0, 3'd2, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 7);
    le("hid_a", 1'b0, 3'd0, 3'd5, 1'b1, tipo_esp(2));
    le("hid_b", 1'b0, 3'd1, 3'd6, 1'b1, tipo_esp(2));
    le("hid_c", 1'b0, 3'd0, 3'd7, 1'b1, tipo_esp(2));
    le("hid_vazio", 1'b0, 3'd1, 3'd5, 1'b0, 0);
    check("cel_j0_8", int'(celulas_j0), 8);

    // Player isolation: same carrier as j0 but for j1.
    req(1'b1, 3'd0, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0, 11);
    check("cel_j1_10", int'(celulas_j1), 10);

    // Invalid type.
    req(1'b0, 3'd5, 3'd3, 3'd3, 1'b0, 1'b0, 1'b1, 2);
    check("conflito_tipo_inv", int'(conflito), 1);

    // Cruiser j0 at (6,0); a second valida during WRITE must be ignored.
    inicia(1'b0, 3'd3, 3'd6, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5);
    repeat (2) @(negedge clk);
    tipo = 3'd4; X1 = 3'd0; Y1 = 3'd0; valida = 1'b1;
    @(negedge clk);
    valida = 1'b0;
    espera_idle();
    repeat (4) @(negedge clk);
    le("valida_ignorada", 1'b0, 3'd0, 3'd0, 1'b0, 0);
    le("cruzador", 1'b0, 3'd7, 3'd0, 1'b1, tipo_esp(3));
    check("cel_j0_10", int'(celulas_j0), 10);

    // limpa in WRITE cycle 2 of a clean carrier (cycle 7).
    inicia(1'b0, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (6) @(negedge clk);
    limpa = 1'b1;
    @(negedge clk);
    limpa = 1'b0;
    check("limpa_ocupado", int'(ocupado), 0);
    check("limpa_cel_j0", int'(celulas_j0), 0);
    check("limpa_cel_j1", int'(celulas_j1), 0);
    check("limpa_conflito", int'(conflito), 0);
    le("limpa_j0", 1'b0, 3'd2, 3'd2, 1'b0, 0);
    le("limpa_j0_novo", 1'b0, 3'd0, 3'd1, 1'b0, 0);
    le("limpa_j1", 1'b1, 3'd0, 3'd4, 1'b0, 0);
    repeat (10) @(negedge clk);

    // limpa and valida together in IDLE: request dropped.
    @(negedge clk);
    jogador = 1'b0; tipo = 3'd4; X1 = 3'd3; Y1 = 3'd3; valida = 1'b1; limpa = 1'b1;
    @(negedge clk);
    valida = 1'b0; limpa = 1'b0;
    check("limpa_vence_ocupado", int'(ocupado), 0);
    repeat (3) @(negedge clk);
    le("limpa_vence_cel", 1'b0, 3'd3, 3'd3, 1'b0, 0);

    // reset mid-CHECK.
    req(1'b0, 3'd0, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 11);
    le("pre_reset", 1'b0, 3'd2, 3'd3, 1'b1, tipo_esp(0));
    check("pre_reset_cel", int'(celulas_j0), 5);
    inicia(1'b0, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("meio_check_ocupado", int'(ocupado), 1);
    reset = 1'b0;
    #1;
    check("rst_mid_ocupado", int'(ocupado), 0);
    check("rst_mid_resposta", int'(resposta), 0);
    check("rst_mid_conflito", int'(conflito), 0);
    check("rst_mid_rd_ocupado", int'(rd_ocupado), 0);
    check("rst_mid_rd_tipo", int'(rd_tipo), 0);
    check("rst_mid_cel_j0", int'(celulas_j0), 0);
    @(negedge clk);
    reset = 1'b1;
    le("pos_reset", 1'b0, 3'd2, 3'd3, 1'b0, 0);
    repeat (15) @(negedge clk);

    check("fila_vazia", fila.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
